// File: rtl/vector_mem_responder.sv
// Memory-side responder for the processing units: round-robin arbitration,
// one transaction at a time through IDLE -> GRANT -> ACCESS -> DONE, over a
// VEC_ENTRIES-deep vector store that the host can preload while idle.
module vector_mem_responder #(
  parameter int NUM_UNITS    = 4,
  parameter int VECTOR_DEPTH = 4,
  parameter int VECTOR_WIDTH = 16,
  parameter int VEC_ENTRIES  = 16,
  parameter int WAIT_CYCLES  = 1,
  localparam int VEC_BITS    = VECTOR_DEPTH * VECTOR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_UNITS-1:0]          mem_request,
  input  logic [4*NUM_UNITS-1:0]        mem_op_type,
  input  logic [4*NUM_UNITS-1:0]        vec_index,
  input  logic [VEC_BITS*NUM_UNITS-1:0] write_data,
  output logic [NUM_UNITS-1:0]          mem_grant,
  output logic [NUM_UNITS-1:0]          mem_done,
  output logic [NUM_UNITS-1:0]          mem_error,
  output logic [VEC_BITS-1:0]           read_data,
  input  logic                          host_we,
  input  logic [3:0]                    host_addr,
  input  logic [VEC_BITS-1:0]           host_wdata,
  output logic                          host_ready
);

  localparam int ID_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [3:0] OP_LOAD    = 4'b0001;
  localparam logic [3:0] OP_STORE   = 4'b0010;
  localparam logic [3:0] OP_COMPUTE = 4'b0100;

  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     id_reg, last_reg;
  logic [3:0]          op_reg, index_reg, count_reg;
  logic [VEC_BITS-1:0] wdata_reg, read_data_reg;
  logic                error_reg;
  logic [VEC_BITS-1:0] store [VEC_ENTRIES];

  logic                found;
  logic [ID_W-1:0]     pick;
  int                  cand;

  // Round-robin pick: first requester searching upward from last+1.
  always_comb begin
    found = 1'b0;
    pick  = last_reg;
    cand  = 0;
    for (int k = 1; k <= NUM_UNITS; k++) begin
      cand = (int'(last_reg) + k) % NUM_UNITS;
      if (!found && mem_request[cand]) begin
        found = 1'b1;
        pick  = ID_W'(cand);
      end
    end
  end

  // Next-state logic; a host write in IDLE blocks arbitration that cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!host_we && found) state_next = GRANT;
      GRANT:   state_next = ACCESS;
      ACCESS:  if (count_reg == 4'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Request latch, wait counter, error flag and read result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_reg        <= '0;
      last_reg      <= ID_W'(NUM_UNITS - 1);
      op_reg        <= '0;
      index_reg     <= '0;
      wdata_reg     <= '0;
      count_reg     <= '0;
      error_reg     <= 1'b0;
      read_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (!host_we && found) begin
          id_reg    <= pick;
          last_reg  <= pick;
          op_reg    <= mem_op_type[4*pick +: 4];
          index_reg <= vec_index[4*pick +: 4];
          wdata_reg <= write_data[VEC_BITS*pick +: VEC_BITS];
        end
        GRANT: count_reg <= 4'(WAIT_CYCLES);
        ACCESS: begin
          count_reg <= count_reg - 4'd1;
          if (count_reg == 4'd1) begin
            error_reg <= !(op_reg == OP_LOAD || op_reg == OP_STORE ||
                           op_reg == OP_COMPUTE);
            if (op_reg == OP_LOAD || op_reg == OP_COMPUTE)
              read_data_reg <= store[index_reg];
          end
        end
        default: ;
      endcase
    end
  end

  // Vector store: host preload in IDLE, unit store commit on the last ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < VEC_ENTRIES; e++) store[e] <= '0;
    end else if (state_reg == IDLE && host_we) begin
      store[host_addr] <= host_wdata;
    end else if (state_reg == ACCESS && count_reg == 4'd1 && op_reg == OP_STORE) begin
      store[index_reg] <= wdata_reg;
    end
  end

  // Per-unit one-hot grant/done/error decoded from state and latched id.
  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
    assign mem_grant[gi] = (state_reg == GRANT) && (id_reg == ID_W'(gi));
    assign mem_done[gi]  = (state_reg == DONE)  && (id_reg == ID_W'(gi));
    assign mem_error[gi] = (state_reg == DONE)  && (id_reg == ID_W'(gi)) && error_reg;
  end

  assign read_data  = read_data_reg;
  assign host_ready = (state_reg == IDLE);

endmodule

// File: tb/tb_vector_mem_responder.sv
// Scoreboard bench for vector_mem_responder: expected grants/completions are
// queued when requests are driven and compared when the DUT produces them.
module tb_vector_mem_responder;

  localparam int VB = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = '0;
  logic [15:0]   ops = '0;
  logic [15:0]   idxs = '0;
  logic [255:0]  wds = '0;
  logic [3:0]    mem_grant, mem_done, mem_error;
  logic [VB-1:0] read_data;
  logic          host_we = 1'b0;
  logic [3:0]    host_addr = '0;
  logic [VB-1:0] host_wdata = '0;
  logic          host_ready;

  // Second instance with a longer access phase.
  logic [3:0]    req3 = '0;
  logic [15:0]   ops3 = '0;
  logic [15:0]   idxs3 = '0;
  logic [255:0]  wds3 = '0;
  logic [3:0]    g3, d3, e3;
  logic [VB-1:0] rd3;
  logic          hr3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          unit;
    int          start;
    int          glat;
    int          dlat;
    logic        err;
    logic [63:0] data;
  } exp_t;

  exp_t        gnt_q[$];
  exp_t        done_q[$];
  logic [63:0] model [16];
  logic [63:0] last_rd;

  vector_mem_responder #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .mem_request(req), .mem_op_type(ops),
    .vec_index(idxs), .write_data(wds), .mem_grant(mem_grant),
    .mem_done(mem_done), .mem_error(mem_error), .read_data(read_data),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready)
  );

  vector_mem_responder #(.WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst_n(rst_n), .mem_request(req3), .mem_op_type(ops3),
    .vec_index(idxs3), .write_data(wds3), .mem_grant(g3),
    .mem_done(d3), .mem_error(e3), .read_data(rd3),
    .host_we(1'b0), .host_addr(4'd0), .host_wdata(64'd0),
    .host_ready(hr3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Queue the expected outcome, advancing the reference store model in order.
  task automatic expect_txn(input int u, input logic [3:0] op, input int idx,
                            input logic [63:0] wd, input int glat, input int dlat);
    exp_t e;
    e.unit = u; e.start = cyc; e.glat = glat; e.dlat = dlat; e.err = 1'b0;
    if (op == 4'b0001 || op == 4'b0100) last_rd = model[idx];
    else if (op == 4'b0010) model[idx] = wd;
    else e.err = 1'b1;
    e.data = last_rd;
    gnt_q.push_back(e);
    done_q.push_back(e);
  endtask

  task automatic set_unit(input int u, input logic [3:0] op, input int idx, input logic [63:0] wd);
    req[u] = 1'b1;
    ops[u*4 +: 4] = op;
    idxs[u*4 +: 4] = 4'(idx);
    wds[u*64 +: 64] = wd;
  endtask

  // Hold requests until each unit sees its own done; drop on the edge after.
  task automatic serve(input int budget);
    logic [3:0] seen;
    int n = 0;
    while (req != 0 && n < budget) begin
      @(negedge clk);
      seen = mem_done;
      @(posedge clk); #1;
      req = req & ~seen;
      n++;
    end
    check("all_served", 64'(req), 64'd0);
    @(negedge clk);
  endtask

  // Monitor: pop and compare on every grant and completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_grant != 0) begin
        if (gnt_q.size() == 0) check("grant_unexpected", 64'(mem_grant), 64'd0);
        else begin
          e = gnt_q.pop_front();
          check("grant_unit", 64'(mem_grant), 64'd1 << e.unit);
          if (e.glat >= 0) check("grant_latency", 64'(cyc - e.start), 64'(e.glat));
          $display("grant unit=%0d cycle=%0d", e.unit, cyc);
        end
      end
      if (mem_done != 0) begin
        if (done_q.size() == 0) check("done_unexpected", 64'(mem_done), 64'd0);
        else begin
          e = done_q.pop_front();
          check("done_unit", 64'(mem_done), 64'd1 << e.unit);
          check("done_error", 64'(mem_error), e.err ? (64'd1 << e.unit) : 64'd0);
          check("read_data", read_data, e.data);
          if (e.dlat >= 0) check("done_latency", 64'(cyc - e.start), 64'(e.dlat));
          $display("done unit=%0d err=%0b data=%h cycle=%0d", e.unit, mem_error[e.unit], read_data, cyc);
        end
      end else if (mem_error != 0) begin
        check("error_without_done", 64'(mem_error), 64'd0);
      end
    end
  end

  initial begin
    int gl, dl;
    logic [63:0] rdv;
    for (int i = 0; i < 16; i++) model[i] = '0;
    last_rd = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_host_ready", 64'(host_ready), 64'd1);
    check("reset_grant", 64'(mem_grant), 64'd0);
    check("reset_done", 64'(mem_done), 64'd0);
    check("reset_error", 64'(mem_error), 64'd0);
    check("reset_read_data", read_data, 64'd0);

    // Host preload, then unit 1 loads it back.
    host_we = 1'b1; host_addr = 4'd5; host_wdata = 64'h0004_0003_0002_0001;
    model[5] = host_wdata;
    @(posedge clk); #1 host_we = 1'b0;
    @(negedge clk);
    set_unit(1, 4'b0001, 5, '0); expect_txn(1, 4'b0001, 5, '0, 1, 3);
    serve(20);

    // Store then load on unit 2; unit 3 checks an untouched index.
    set_unit(2, 4'b0010, 9, 64'hFFFF_0000_1234_8000);
    expect_txn(2, 4'b0010, 9, 64'hFFFF_0000_1234_8000, 1, 3);
    serve(20);
    set_unit(2, 4'b0001, 9, '0); expect_txn(2, 4'b0001, 9, '0, 1, 3);
    serve(20);
    set_unit(3, 4'b0001, 10, '0); expect_txn(3, 4'b0001, 10, '0, 1, 3);
    serve(20);

    // Round-robin: all four request together; expected order 0,1,2,3.
    set_unit(0, 4'b0001, 5, '0);
    set_unit(1, 4'b0010, 12, 64'hDEAD_BEEF_CAFE_0123);
    set_unit(2, 4'b0001, 12, '0);
    set_unit(3, 4'b0100, 9, '0);
    expect_txn(0, 4'b0001, 5, '0, 1, 3);
    expect_txn(1, 4'b0010, 12, 64'hDEAD_BEEF_CAFE_0123, -1, -1);
    expect_txn(2, 4'b0001, 12, '0, -1, -1);
    expect_txn(3, 4'b0100, 9, '0, -1, -1);
    serve(60);
    set_unit(0, 4'b0001, 9, '0);
    set_unit(3, 4'b0010, 5, 64'h1111_2222_3333_4444);
    expect_txn(0, 4'b0001, 9, '0, 1, 3);
    expect_txn(3, 4'b0010, 5, 64'h1111_2222_3333_4444, -1, -1);
    serve(40);

    // Illegal op flags an error and leaves store and read_data alone.
    set_unit(3, 4'b1000, 5, 64'h5555_5555_5555_5555);
    expect_txn(3, 4'b1000, 5, 64'h5555_5555_5555_5555, 1, 3);
    serve(20);
    set_unit(3, 4'b0001, 5, '0); expect_txn(3, 4'b0001, 5, '0, 1, 3);
    serve(20);

    // Host write and unit request in the same cycle: host first.
    host_we = 1'b1; host_addr = 4'd14; host_wdata = 64'hA5A5_0F0F_F0F0_5A5A;
    model[14] = host_wdata;
    set_unit(0, 4'b0100, 14, '0); expect_txn(0, 4'b0100, 14, '0, 2, 4);
    @(posedge clk); #1 host_we = 1'b0;
    serve(20);

    // Reset during ACCESS of a store: no done, store cleared, priority restarts.
    set_unit(1, 4'b0010, 7, 64'h7777_7777_7777_7777);
    begin
      exp_t e;
      e.unit = 1; e.start = cyc; e.glat = 1; e.dlat = -1; e.err = 1'b0; e.data = '0;
      gnt_q.push_back(e);
    end
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    req = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    last_rd = '0;
    repeat (2) begin
      @(negedge clk);
      check("reset_no_done", 64'(mem_done), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_read_data", read_data, 64'd0);
    check("post_reset_ready", 64'(host_ready), 64'd1);
    set_unit(2, 4'b0001, 7, '0);
    set_unit(0, 4'b0001, 2, '0);
    expect_txn(0, 4'b0001, 2, '0, 1, 3);
    expect_txn(2, 4'b0001, 7, '0, -1, -1);
    serve(40);

    // WAIT_CYCLES=3 instance: grant at cycle 1, done at cycle 5.
    gl = -1; dl = -1; rdv = '1;
    begin
      int c0;
      c0 = cyc;
      req3[0] = 1'b1; ops3[3:0] = 4'b0001; idxs3[3:0] = 4'd0;
      for (int i = 0; i < 12 && dl < 0; i++) begin
        @(negedge clk);
        if (g3[0]) gl = cyc - c0;
        if (d3[0]) begin dl = cyc - c0; rdv = rd3; end
      end
      @(posedge clk); #1 req3 = '0;
    end
    check("w3_grant_latency", 64'(gl), 64'd1);
    check("w3_done_latency", 64'(dl), 64'd5);
    check("w3_read_data", rdv, 64'd0);
    $display("w3 load grant_lat=%0d done_lat=%0d data=%h", gl, dl, rdv);

    check("grant_queue_empty", 64'(gnt_q.size()), 64'd0);
    check("done_queue_empty", 64'(done_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vector_mem_responder.md
Name: vector_mem_responder

Overview:
- Memory-side responder for the processing units' memory request interface; serves up to NUM_UNITS requesters.
- Holds a VEC_ENTRIES-deep vector store and serves load, store and compute-operand reads.
- Arbitration is round-robin, one transaction at a time; each completion is signalled by a one-cycle mem_done pulse.
- Includes a host preload port for initialising vectors before a run.

Parameters:
NUM_UNITS, 4, number of requesting units (unit id width 2)
VECTOR_DEPTH, 4, elements per vector
VECTOR_WIDTH, 16, bits per element; VEC_BITS = VECTOR_DEPTH*VECTOR_WIDTH
VEC_ENTRIES, 16, vectors in store, addressed by 4-bit vec_index
WAIT_CYCLES, 1, access-phase cycles (legal range 1..15)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
mem_request  input  NUM_UNITS  per-unit request level, held until that unit's mem_done is seen
mem_op_type  input  4*NUM_UNITS  per-unit op: 0001 load, 0010 store, 0100 compute read
vec_index  input  4*NUM_UNITS  per-unit vector address
write_data  input  VEC_BITS*NUM_UNITS  per-unit store data
mem_grant  output  NUM_UNITS  one-hot grant pulse
mem_done  output  NUM_UNITS  one-hot completion pulse
mem_error  output  NUM_UNITS  one-hot error flag, valid with mem_done
read_data  output  VEC_BITS  shared read result, valid with mem_done, held until next read completes
host_we  input  1  host preload write strobe
host_addr  input  4  host preload address
host_wdata  input  VEC_BITS  host preload data
host_ready  output  1  high when state is IDLE

Behaviour:
- Clock and reset: clk rising edge; reset rst_n asynchronous, active-low.
- Reset values: all outputs 0 except host_ready=1; state IDLE; store cleared to 0; round-robin pointer last=NUM_UNITS-1, so unit 0 has first priority.
- Reset mid-transaction aborts it: no grant or done is emitted; a store not yet committed is lost.
- States:
  - IDLE → GRANT → ACCESS → DONE → IDLE.
- IDLE:
  - If host_we=1: write host_wdata to store[host_addr]; no arbitration that cycle; stay IDLE.
  - Else if any mem_request: select the first requesting unit searching from last+1 modulo NUM_UNITS.
  - Latch the selected unit's id, op, index and write_data; set last=id; go to GRANT.
- GRANT (1 cycle): mem_grant[id]=1; load wait counter with WAIT_CYCLES.
- ACCESS (WAIT_CYCLES cycles, counter decrements each cycle). On the final cycle:
  - op 0001 or 0100: latch store[index] into read_data.
  - op 0010: commit latched write_data to store[index]; read_data unchanged.
  - Any other op: no store access; set error flag.
- DONE (1 cycle): mem_done[id]=1; mem_error[id]=error flag. No arbitration in this cycle, because the unit drops mem_request on the edge that samples done. Then go to IDLE.
- Timing with WAIT_CYCLES=1: request sampled at edge 0 → mem_grant high cycle 1 → access cycle 2 → mem_done high cycle 3. Next grant no earlier than cycle 5.
- The latched op/index/data are used throughout; requester input changes after the latch are ignored.
- Store-then-load to the same index returns the new data.
- Host writes are accepted only in IDLE; host_we in other states is ignored (host must check host_ready).
- Simultaneous host_we and unit requests in IDLE: host wins; units are served starting the next cycle.
- Index wrap: indices are 4-bit, so all values are in range; no bounds error.
- Non-requesting units: all their grant/done/error bits stay 0.

Test Plan:
- Preload: host writes 0x0004_0003_0002_0001 to addr 5; unit 1 loads index 5 → mem_grant[1] at cycle 1, mem_done[1] at cycle 3, read_data=0x0004_0003_0002_0001, mem_error=0.
- Store then load: unit 2 stores 0xFFFF_0000_1234_8000 to index 9, then loads index 9 → second done returns identical data; other indices still 0.
- Round-robin: units 0–3 request together, each holding until its own done → grants in order 0,1,2,3. Then units 0 and 3 re-request → 0 first (last=3).
- Illegal op 1000 from unit 3 → mem_done[3]=1 with mem_error[3]=1; read_data and store unchanged.
- Contention: host_we together with a unit 0 request in IDLE → host write lands, mem_grant[0] one cycle later. Separately, WAIT_CYCLES=3 → done at cycle 5.
- Reset during ACCESS of a store → no mem_done; store entry stays 0. After release, a load of that index returns 0 and grant priority restarts at unit 0.
